// File: rtl/ex_mem_register_pkg.sv
// Shared constants and types for the EX/MEM pipeline register and its CCR unit.
// Optional feature macro used by this slice: CCR_SHADOW_EN (interrupt shadow CCR).
package ex_mem_register_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;
    localparam int CCR_W      = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic valid;
        logic reg_we;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    // Bits selected by mask take the new value, the rest keep the old one.
    function automatic logic [CCR_W-1:0] ccr_merge(input logic [CCR_W-1:0] old_v,
                                                   input logic [CCR_W-1:0] new_v,
                                                   input logic [CCR_W-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/ex_mem_register_ccr_unit.sv
// Condition code register with per-flag write mask and, under CCR_SHADOW_EN,
// a one-deep shadow copy used for interrupt save/restore.
module ccr_unit
    import ex_mem_register_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_en,
    input  logic [CCR_W-1:0] flag_we,
    input  logic [CCR_W-1:0] flags_in,
    input  logic             int_save,
    input  logic             int_restore,
    output logic [CCR_W-1:0] ccr
);

    logic [CCR_W-1:0] ccr_q, ccr_d, ccr_upd;

    always_comb begin
        ccr_upd = ccr_q;
        if (upd_en) ccr_upd = ccr_merge(ccr_q, flags_in, flag_we);
    end

`ifdef CCR_SHADOW_EN
    logic [CCR_W-1:0] shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;

    // Restore beats save; save snapshots the post-update value of this edge.
    always_comb begin
        ccr_d          = ccr_upd;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        if (int_restore) begin
            if (shadow_valid_q) ccr_d = shadow_q;
            shadow_valid_d = 1'b0;
        end else if (int_save) begin
            shadow_d       = ccr_upd;
            shadow_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end
`else
    logic unused_int;

    always_comb ccr_d = ccr_upd;
    assign unused_int = int_save | int_restore;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ccr_q <= '0;
        else     ccr_q <= ccr_d;
    end

    assign ccr = ccr_q;

endmodule

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall/flush and an attached condition code register.
// Define CCR_SHADOW_EN to add the interrupt shadow CCR inside ccr_unit.
module ex_mem_register
    import ex_mem_register_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero_in,
    input  logic              neg_in,
    input  logic              carry_in,
    input  logic              ovf_in,
    input  logic [CCR_W-1:0]  flag_we,
    input  logic [REG_AW-1:0] rdst,
    input  logic              reg_we,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] store_data,
    input  logic              int_save,
    input  logic              int_restore,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rdst,
    output logic              out_reg_we,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] out_store_data,
    output logic [CCR_W-1:0]  ccr
);

    mem_ctrl_t         ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [REG_AW-1:0] rdst_q, rdst_d;
    logic              upd_en;
    logic [CCR_W-1:0]  flags_in;

    // Flush only kills control; data fields keep their last values.
    always_comb begin
        ctrl_d   = ctrl_q;
        result_d = result_q;
        store_d  = store_q;
        rdst_d   = rdst_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d.valid     = in_valid;
            ctrl_d.reg_we    = in_valid & reg_we;
            ctrl_d.mem_read  = in_valid & mem_read;
            ctrl_d.mem_write = in_valid & mem_write;
            result_d         = alu_result;
            store_d          = store_data;
            rdst_d           = rdst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            result_q <= '0;
            store_q  <= '0;
            rdst_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            store_q  <= store_d;
            rdst_q   <= rdst_d;
        end
    end

    always_comb begin
        upd_en           = in_valid & ~stall & ~flush;
        flags_in         = '0;
        flags_in[FLAG_Z] = zero_in;
        flags_in[FLAG_N] = neg_in;
        flags_in[FLAG_C] = carry_in;
        flags_in[FLAG_V] = ovf_in;
    end

    ccr_unit u_ccr (
        .clk         (clk),
        .rst         (rst),
        .upd_en      (upd_en),
        .flag_we     (flag_we),
        .flags_in    (flags_in),
        .int_save    (int_save),
        .int_restore (int_restore),
        .ccr         (ccr)
    );

    assign out_valid      = ctrl_q.valid;
    assign out_reg_we     = ctrl_q.reg_we;
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_result     = result_q;
    assign out_store_data = store_q;
    assign out_rdst       = rdst_q;

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed + randomized scoreboard bench for ex_mem_register (default and CCR_SHADOW_EN builds).
module tb_ex_mem_register;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk, rst, stall, flush, in_valid;
    logic [DW-1:0] alu_result, store_data;
    logic          zero_in, neg_in, carry_in, ovf_in;
    logic [3:0]    flag_we;
    logic [AW-1:0] rdst;
    logic          reg_we, mem_read, mem_write, int_save, int_restore;
    logic          out_valid, out_reg_we, out_mem_read, out_mem_write;
    logic [DW-1:0] out_result, out_store_data;
    logic [AW-1:0] out_rdst;
    logic [3:0]    ccr;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] result;
        logic [AW-1:0] rdst;
        logic          reg_we;
        logic          mem_read;
        logic          mem_write;
        logic [DW-1:0] store;
        logic [3:0]    ccr;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;               // reference state of the register
    logic [3:0] m_shadow;
    logic       m_shvalid;
    int vectors = 0;
    int miscompares = 0;

    ex_mem_register #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .zero_in(zero_in), .neg_in(neg_in), .carry_in(carry_in),
        .ovf_in(ovf_in), .flag_we(flag_we), .rdst(rdst), .reg_we(reg_we),
        .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
        .int_save(int_save), .int_restore(int_restore), .out_valid(out_valid),
        .out_result(out_result), .out_rdst(out_rdst), .out_reg_we(out_reg_we),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .ccr(ccr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".valid"},  32'(out_valid),      32'(e.valid));
        chk({tag, ".result"}, 32'(out_result),     32'(e.result));
        chk({tag, ".rdst"},   32'(out_rdst),       32'(e.rdst));
        chk({tag, ".reg_we"}, 32'(out_reg_we),     32'(e.reg_we));
        chk({tag, ".mrd"},    32'(out_mem_read),   32'(e.mem_read));
        chk({tag, ".mwr"},    32'(out_mem_write),  32'(e.mem_write));
        chk({tag, ".store"},  32'(out_store_data), 32'(e.store));
        chk({tag, ".ccr"},    32'(ccr),            32'(e.ccr));
    endtask

    // Advance the reference by one edge from the current inputs and push the expectation.
    task automatic model_push();
        logic [3:0] fl, upd;
        fl  = {ovf_in, carry_in, neg_in, zero_in};
        upd = m.ccr;
        if (in_valid && !stall && !flush) upd = (m.ccr & ~flag_we) | (fl & flag_we);
        if (flush) begin
            m.valid = 0; m.reg_we = 0; m.mem_read = 0; m.mem_write = 0;
        end else if (!stall) begin
            m.valid     = in_valid;
            m.reg_we    = in_valid & reg_we;
            m.mem_read  = in_valid & mem_read;
            m.mem_write = in_valid & mem_write;
            m.result    = alu_result;
            m.rdst      = rdst;
            m.store     = store_data;
        end
`ifdef CCR_SHADOW_EN
        if (int_restore) begin
            if (m_shvalid) upd = m_shadow;
            m_shvalid = 0;
        end else if (int_save) begin
            m_shadow  = upd;
            m_shvalid = 1;
        end
`endif
        m.ccr = upd;
        exp_q.push_back(m);
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_all(tag, e);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 0; alu_result = '0; store_data = '0;
        zero_in = 0; neg_in = 0; carry_in = 0; ovf_in = 0; flag_we = '0; rdst = '0;
        reg_we = 0; mem_read = 0; mem_write = 0; int_save = 0; int_restore = 0;
    endtask

    task automatic alu_op(input logic [DW-1:0] res, input logic [3:0] fl, input logic [3:0] we);
        in_valid = 1; alu_result = res; flag_we = we;
        {ovf_in, carry_in, neg_in, zero_in} = fl;
    endtask

    task automatic do_reset_midstream(input string tag);
        #2 rst = 1;
        #1;
        m = '0; m_shadow = '0; m_shvalid = 0;
        exp_q.delete();
        chk_all(tag, m);
        @(negedge clk) rst = 0;
    endtask

    initial begin
        m = '0; m_shadow = '0; m_shvalid = 0;
        idle_inputs();
        rst = 1;
        #12;
        chk_all("reset", m);
        @(negedge clk) rst = 0;

        // Capture with flag mask: only Z written although carry_in is also set.
        alu_op(16'h0000, 4'b0101, 4'b0001);
        reg_we = 1; rdst = 3'd5; store_data = 16'hBEEF;
        step("capture");
        chk("capture.ccr_lit", 32'(ccr), 32'h1);
        chk("capture.res_lit", 32'(out_result), 32'h0);

        // Stall holds everything, including ccr.
        stall = 1; alu_op(16'h1234, 4'b1111, 4'b1111); rdst = 3'd2;
        step("stall");
        chk("stall.res_lit", 32'(out_result), 32'h0);

        // Flush with stall: bubble wins, data and ccr hold.
        flush = 1;
        step("stall_flush");
        chk("stall_flush.valid_lit", 32'(out_valid), 32'h0);
        chk("stall_flush.ccr_lit", 32'(ccr), 32'h1);

        // Invalid instruction: control captured as 0, flags ignored.
        idle_inputs(); reg_we = 1; mem_write = 1; mem_read = 1; flag_we = 4'hF;
        zero_in = 0; neg_in = 1; carry_in = 1; ovf_in = 1; alu_result = 16'h5555;
        step("invalid");
        chk("invalid.mwr_lit", 32'(out_mem_write), 32'h0);
        chk("invalid.ccr_lit", 32'(ccr), 32'h1);

        // Randomized traffic across stall/flush/mask combinations.
        for (int i = 0; i < 24; i++) begin
            idle_inputs();
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 4) == 0);
            in_valid   = $urandom_range(0, 1);
            alu_result = DW'($urandom);
            store_data = DW'($urandom);
            rdst       = AW'($urandom);
            {reg_we, mem_read, mem_write} = 3'($urandom);
            flag_we    = 4'($urandom);
            {ovf_in, carry_in, neg_in, zero_in} = 4'($urandom);
            step("rand");
        end

        // Shadow sequence: 0101 -> save -> 1010 -> restore -> restore again.
        idle_inputs(); alu_op(16'h0101, 4'b0101, 4'hF);
        step("set0101");
        idle_inputs(); int_save = 1;
        step("save");
        idle_inputs(); alu_op(16'h1010, 4'b1010, 4'hF);
        step("set1010");
        idle_inputs(); int_restore = 1;
        step("restore1");
`ifdef CCR_SHADOW_EN
        chk("restore1.ccr_lit", 32'(ccr), 32'h5);
`else
        chk("restore1.ccr_lit", 32'(ccr), 32'hA);
`endif
        step("restore2");
`ifdef CCR_SHADOW_EN
        chk("restore2.ccr_lit", 32'(ccr), 32'h5);
`else
        chk("restore2.ccr_lit", 32'(ccr), 32'hA);
`endif

        // Same-edge save captures the updated value; also under stall+flush.
        idle_inputs(); alu_op(16'h0044, 4'b0100, 4'hF); int_save = 1;
        step("save_same_edge");
        idle_inputs(); alu_op(16'h0011, 4'b0001, 4'hF);
        step("set0001");
        idle_inputs(); stall = 1; flush = 1; int_restore = 1; int_save = 1;
        step("restore_wins");
`ifdef CCR_SHADOW_EN
        chk("restore_wins.ccr_lit", 32'(ccr), 32'h4);
`else
        chk("restore_wins.ccr_lit", 32'(ccr), 32'h1);
`endif

        // Mid-stream reset discards in-flight data and any saved shadow.
        idle_inputs(); alu_op(16'h7E7E, 4'b1001, 4'hF); reg_we = 1; int_save = 1;
        step("pre_reset");
        idle_inputs(); alu_op(16'h3C3C, 4'b0110, 4'hF);
        do_reset_midstream("reset_mid");
        idle_inputs(); int_restore = 1;
        step("restore_after_reset");
        idle_inputs(); alu_op(16'hA5A5, 4'b0010, 4'b0010); mem_read = 1; rdst = 3'd7;
        step("resume");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
